// File: rtl/uart_loopback_bist_if.sv
// uart_loopback_bist_if: run-control and serial-line bundle for the UART loopback BIST.
//   START       - one-cycle run request (master -> slave)
//   RsRx        - serial receive line, asynchronous to the clock (master -> slave)
//   RsTx        - serial transmit line, idles high (slave -> master)
//   BUSY/DONE   - run in progress / run finished (slave -> master)
//   PASS        - run finished with no errored frames, valid while DONE (slave -> master)
//   ERR_COUNT   - errored frames in the current or last run (slave -> master)
//   FRAME_COUNT - frames resolved in the current run (slave -> master)
interface uart_loopback_bist_if;
  logic        START;
  logic        RsRx;
  logic        RsTx;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [15:0] ERR_COUNT;
  logic [15:0] FRAME_COUNT;

  modport master (
    output START, RsRx,
    input  RsTx, BUSY, DONE, PASS, ERR_COUNT, FRAME_COUNT
  );

  modport slave (
    input  START, RsRx,
    output RsTx, BUSY, DONE, PASS, ERR_COUNT, FRAME_COUNT
  );
endinterface

// File: rtl/uart_loopback_bist.sv
// uart_loopback_bist: sends NUM_FRAMES UART frames with an incrementing payload
// (starting at SEED), waits for each to come back on RsRx, and counts frames whose
// echo is wrong (data, parity or stop bit) or never arrives.
//   CLK   - single clock, rising edge
//   RESET - synchronous, active-high
//   bus   - slave side of uart_loopback_bist_if (START, RsRx in; RsTx, BUSY, DONE,
//           PASS, ERR_COUNT, FRAME_COUNT out)
module uart_loopback_bist #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int NUM_FRAMES   = 16,
  parameter int SEED         = 8'hA5,
  parameter int TIMEOUT_CLKS = 4*CLKS_PER_BIT
) (
  input logic CLK,
  input logic RESET,
  uart_loopback_bist_if.slave bus
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START_BIT  = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
  localparam logic [2:0] PARITY_BIT = 3'd3;
  localparam logic [2:0] STOP       = 3'd4;
  localparam logic [2:0] WAIT_RX    = 3'd5;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_BITS  = 2'd2;

  // Bits after the start bit: data, optional parity, stop bits.
  localparam int RX_W = DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

  localparam logic [15:0]          BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]          HALF_LAST = 16'(CLKS_PER_BIT/2 - 1);
  localparam logic [3:0]           DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]           STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]           RX_LAST   = 4'(RX_W - 1);
  localparam logic [31:0]          TO_LAST   = 32'(TIMEOUT_CLKS - 1);
  localparam logic [15:0]          NF        = 16'(NUM_FRAMES);
  localparam logic [DATA_BITS-1:0] SEED_D    = DATA_BITS'(SEED);
  localparam logic [DATA_BITS-1:0] ONE_D     = DATA_BITS'(1);

  // TX side / run control
  logic [2:0]           txState;
  logic [15:0]          txCnt;
  logic [3:0]           txIdx;
  logic [DATA_BITS-1:0] txShift;
  logic [DATA_BITS-1:0] payload;
  logic                 txLine;
  logic                 busy, done, pass;
  logic [15:0]          errCount, frameCount;
  logic [31:0]          waitCnt;

  // RX side
  logic                 sync1, sync2, syncPrev;
  logic [1:0]           rxState;
  logic [15:0]          rxCnt;
  logic [3:0]           rxIdx;
  logic [RX_W-2:0]      rxShift;
  logic                 rxStale, rxPending, rxPendErr;

  logic                 startAcc, rxBusy, rxStartEv, rxLastSample;
  logic                 resolve, resolveErr, lastFrame, frameStart;
  logic                 parityBit, rxParErr, rxFrameErr;
  logic [RX_W-1:0]      rxVec;
  logic [DATA_BITS-1:0] rxData;
  logic [STOP_BITS-1:0] rxStops;

  assign startAcc     = bus.START && !busy;
  assign rxBusy       = rxState != RX_IDLE;
  assign rxStartEv    = (rxState == RX_IDLE) && syncPrev && !sync2;
  assign rxLastSample = (rxState == RX_BITS) && (rxCnt == BIT_LAST) && (rxIdx == RX_LAST);

  // Received bits arrive LSB first and shift in from the top; rxVec is the frame
  // including the bit being sampled this cycle.
  assign rxVec   = {sync2, rxShift};
  assign rxData  = rxVec[DATA_BITS-1:0];
  assign rxStops = rxVec[RX_W-1 -: STOP_BITS];

  assign parityBit = (PARITY == 2) ? ~^payload : ^payload;

  always_comb begin
    rxParErr = 1'b0;
    if (PARITY == 1)      rxParErr = ^rxVec[DATA_BITS:0];
    else if (PARITY == 2) rxParErr = ~^rxVec[DATA_BITS:0];
  end

  assign rxFrameErr = (rxData != payload) || rxParErr || !(&rxStops);

  // A frame resolves on a pending echo, or as a timeout once the wait has expired
  // with no reception in progress.
  assign resolve    = (txState == WAIT_RX) && (rxPending || (!rxBusy && waitCnt >= TO_LAST));
  assign resolveErr = rxPending ? rxPendErr : 1'b1;
  assign lastFrame  = (frameCount + 16'd1) == NF;
  assign frameStart = ((txState == IDLE) && startAcc) || (resolve && !lastFrame);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      txState    <= IDLE;
      txCnt      <= '0;
      txIdx      <= '0;
      txShift    <= '0;
      payload    <= SEED_D;
      txLine     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      errCount   <= '0;
      frameCount <= '0;
      waitCnt    <= '0;
    end else begin
      case (txState)
        IDLE: if (startAcc) begin
          busy       <= 1'b1;
          done       <= 1'b0;
          pass       <= 1'b0;
          errCount   <= '0;
          frameCount <= '0;
          payload    <= SEED_D;
          txLine     <= 1'b0;
          txCnt      <= '0;
          txState    <= START_BIT;
        end
        START_BIT: if (txCnt == BIT_LAST) begin
          txCnt   <= '0;
          txLine  <= payload[0];
          txShift <= payload >> 1;
          txIdx   <= '0;
          txState <= DATA;
        end else txCnt <= txCnt + 16'd1;
        DATA: if (txCnt == BIT_LAST) begin
          txCnt <= '0;
          if (txIdx == DATA_LAST) begin
            txIdx <= '0;
            if (PARITY != 0) begin
              txLine  <= parityBit;
              txState <= PARITY_BIT;
            end else begin
              txLine  <= 1'b1;
              txState <= STOP;
            end
          end else begin
            txLine  <= txShift[0];
            txShift <= txShift >> 1;
            txIdx   <= txIdx + 4'd1;
          end
        end else txCnt <= txCnt + 16'd1;
        PARITY_BIT: if (txCnt == BIT_LAST) begin
          txCnt   <= '0;
          txLine  <= 1'b1;
          txState <= STOP;
        end else txCnt <= txCnt + 16'd1;
        STOP: if (txCnt == BIT_LAST) begin
          txCnt <= '0;
          if (txIdx == STOP_LAST) begin
            waitCnt <= '0;
            txState <= WAIT_RX;
          end else txIdx <= txIdx + 4'd1;
        end else txCnt <= txCnt + 16'd1;
        WAIT_RX: if (resolve) begin
          frameCount <= frameCount + 16'd1;
          if (resolveErr && errCount != 16'hFFFF) errCount <= errCount + 16'd1;
          payload <= payload + ONE_D;
          if (lastFrame) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (errCount == 16'd0) && !resolveErr;
            txState <= IDLE;
          end else begin
            txLine  <= 1'b0;
            txCnt   <= '0;
            txState <= START_BIT;
          end
        end else if (waitCnt < TO_LAST) waitCnt <= waitCnt + 32'd1;
        default: txState <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      syncPrev  <= 1'b1;
      rxState   <= RX_IDLE;
      rxCnt     <= '0;
      rxIdx     <= '0;
      rxShift   <= '0;
      rxStale   <= 1'b0;
      rxPending <= 1'b0;
      rxPendErr <= 1'b0;
    end else begin
      sync1    <= bus.RsRx;
      sync2    <= sync1;
      syncPrev <= sync2;

      case (rxState)
        RX_IDLE: if (rxStartEv) begin
          rxCnt   <= '0;
          rxState <= RX_START;
        end
        RX_START: if (rxCnt == HALF_LAST) begin
          rxCnt   <= '0;
          rxIdx   <= '0;
          // High at mid start bit: a glitch, drop it silently.
          rxState <= sync2 ? RX_IDLE : RX_BITS;
        end else rxCnt <= rxCnt + 16'd1;
        RX_BITS: if (rxCnt == BIT_LAST) begin
          rxCnt   <= '0;
          rxShift <= rxVec[RX_W-1:1];
          if (rxIdx == RX_LAST) rxState <= RX_IDLE;
          else                  rxIdx   <= rxIdx + 4'd1;
        end else rxCnt <= rxCnt + 16'd1;
        default: rxState <= RX_IDLE;
      endcase

      // A reception already under way when a new frame goes out belongs to an
      // earlier (timed-out or pre-run) frame and must not be credited.
      if (rxStartEv)                rxStale <= frameStart;
      else if (frameStart && rxBusy) rxStale <= 1'b1;

      if (frameStart || resolve) rxPending <= 1'b0;
      else if (rxLastSample && !rxStale && busy) begin
        rxPending <= 1'b1;
        rxPendErr <= rxFrameErr;
      end
    end
  end

  assign bus.RsTx        = txLine;
  assign bus.BUSY        = busy;
  assign bus.DONE        = done;
  assign bus.PASS        = pass;
  assign bus.ERR_COUNT   = errCount;
  assign bus.FRAME_COUNT = frameCount;

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Bench for uart_loopback_bist. Three instances:
//   dutA - defaults, RsRx echoes RsTx through a line model that can invert chosen
//          bits of chosen frames, hold the line high, or glitch it low
//   dutB - NUM_FRAMES=4, RsRx tied high (every frame times out)
//   dutC - 7 data bits, odd parity, 2 stop bits, CLKS_PER_BIT=8; echo can invert
//          the parity bit of every frame
`timescale 1ns/1ps
module tb_uart_loopback_bist;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam int A_CPB = 16;
  localparam int A_NF  = 16;
  localparam int A_LEN = 10*A_CPB;   // start + 8 data + 1 stop
  localparam int C_CPB = 8;
  localparam int C_NF  = 6;
  localparam int C_LEN = 11*C_CPB;   // start + 7 data + parity + 2 stop

  uart_loopback_bist_if ifA();
  uart_loopback_bist_if ifB();
  uart_loopback_bist_if ifC();

  uart_loopback_bist dutA (.CLK(clk), .RESET(rst), .bus(ifA));
  uart_loopback_bist #(.NUM_FRAMES(4)) dutB (.CLK(clk), .RESET(rst), .bus(ifB));
  uart_loopback_bist #(.DATA_BITS(7), .CLKS_PER_BIT(C_CPB), .PARITY(2), .STOP_BITS(2),
                       .NUM_FRAMES(C_NF)) dutC (.CLK(clk), .RESET(rst), .bus(ifC));

  // ---------------- dutA line model ----------------
  // aPlan[k]: bit position (1..8 data, 9 stop) to invert in frame k, 0 = clean echo.
  int         aPlan [A_NF];
  logic       aHold = 1'b0;
  logic       aGlitch = 1'b0;
  logic       aInv = 1'b0;
  logic       aIn = 1'b0;
  int         aNext = 0;     // index within the frame of the cycle now running
  int         aFrame = 0;    // frames seen in the current run
  logic [7:0] aSeen [A_NF];  // payload decoded from RsTx per frame

  assign ifA.RsRx = aGlitch ? 1'b0 : (aHold | (ifA.RsTx ^ aInv));

  always @(posedge clk) begin
    if (rst || (ifA.START && !ifA.BUSY)) begin
      aIn <= 1'b0; aInv <= 1'b0; aFrame <= 0; aNext <= 0;
    end else if (!aIn) begin
      if (!ifA.RsTx) begin aIn <= 1'b1; aNext <= 1; end
    end else begin
      if (aNext % A_CPB == A_CPB/2 && aNext/A_CPB >= 1 && aNext/A_CPB <= 8 && aFrame < A_NF)
        aSeen[aFrame][aNext/A_CPB - 1] <= ifA.RsTx;
      if (aNext + 1 == A_LEN) begin
        aIn <= 1'b0; aInv <= 1'b0; aFrame <= aFrame + 1;
      end else begin
        aNext <= aNext + 1;
        aInv  <= (aFrame < A_NF) && (aPlan[aFrame] != 0) && ((aNext + 1)/A_CPB == aPlan[aFrame]);
      end
    end
  end

  // ---------------- dutB: no echo ----------------
  assign ifB.RsRx = 1'b1;

  // ---------------- dutC line model ----------------
  logic cInvPar = 1'b0;
  logic cInv = 1'b0;
  logic cIn = 1'b0;
  int   cNext = 0;
  int   cFrames = 0;

  assign ifC.RsRx = ifC.RsTx ^ cInv;

  always @(posedge clk) begin
    if (rst || (ifC.START && !ifC.BUSY)) begin
      cIn <= 1'b0; cInv <= 1'b0; cNext <= 0; cFrames <= 0;
    end else if (!cIn) begin
      if (!ifC.RsTx) begin cIn <= 1'b1; cNext <= 1; end
    end else if (cNext + 1 == C_LEN) begin
      cIn <= 1'b0; cInv <= 1'b0; cFrames <= cFrames + 1;
    end else begin
      cNext <= cNext + 1;
      cInv  <= cInvPar && ((cNext + 1)/C_CPB == 8);   // bit 8 = parity
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // One full dutA run; expErr comes from the corruption plan.
  task automatic runA(input string tag, input int expErr, input bit midStart);
    int n;
    @(posedge clk); #1;
    check({tag, "_idleTx"}, ifA.RsTx, 1);
    ifA.START = 1'b1;
    @(posedge clk); #1;
    ifA.START = 1'b0;
    check({tag, "_startBit"}, ifA.RsTx, 0);
    check({tag, "_busy"}, ifA.BUSY, 1);
    check({tag, "_doneClr"}, ifA.DONE, 0);
    check({tag, "_cntClr"}, {ifA.ERR_COUNT, ifA.FRAME_COUNT}, 0);
    n = 0;
    while (!ifA.DONE && n < 8000) begin
      ifA.START = midStart && (n == 700);
      @(posedge clk); #1;
      n++;
    end
    ifA.START = 1'b0;
    check({tag, "_done"}, ifA.DONE, 1);
    check({tag, "_busyLow"}, ifA.BUSY, 0);
    check({tag, "_pass"}, ifA.PASS, (expErr == 0) ? 1 : 0);
    check({tag, "_errCount"}, ifA.ERR_COUNT, expErr);
    check({tag, "_frameCount"}, ifA.FRAME_COUNT, A_NF);
    check({tag, "_framesOnLine"}, aFrame, A_NF);
    for (int k = 0; k < A_NF; k++)
      check({tag, "_payload"}, aSeen[k], (32'hA5 + k) % 256);
  endtask

  task automatic runC(input string tag, input logic inv, input int expErr);
    int n;
    cInvPar = inv;
    @(posedge clk); #1;
    ifC.START = 1'b1;
    @(posedge clk); #1;
    ifC.START = 1'b0;
    check({tag, "_startBit"}, ifC.RsTx, 0);
    n = 0;
    while (!ifC.DONE && n < 4000) begin @(posedge clk); #1; n++; end
    check({tag, "_done"}, ifC.DONE, 1);
    check({tag, "_pass"}, ifC.PASS, (expErr == 0) ? 1 : 0);
    check({tag, "_errCount"}, ifC.ERR_COUNT, expErr);
    check({tag, "_frameCount"}, ifC.FRAME_COUNT, C_NF);
    check({tag, "_framesOnLine"}, cFrames, C_NF);
    cInvPar = 1'b0;
  endtask

  initial begin
    int nErr;
    int n;
    rst = 1'b1;
    ifA.START = 1'b0; ifB.START = 1'b0; ifC.START = 1'b0;
    for (int k = 0; k < A_NF; k++) aPlan[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_RsTx", ifA.RsTx, 1);
    check("rst_flags", {ifA.BUSY, ifA.DONE, ifA.PASS}, 0);
    check("rst_counts", {ifA.ERR_COUNT, ifA.FRAME_COUNT}, 0);
    check("rstB_state", {ifB.RsTx, ifB.BUSY, ifB.DONE, ifB.PASS}, 4'b1000);
    rst = 1'b0;

    // Clean loopback, then a low glitch while idle must leave the results alone.
    runA("clean", 0, 1'b0);
    @(posedge clk); #1;
    aGlitch = 1'b1;
    repeat (2) @(posedge clk);
    #1 aGlitch = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_counts", {ifA.ERR_COUNT, ifA.FRAME_COUNT}, {16'd0, 16'd16});
    check("glitch_flags", {ifA.BUSY, ifA.DONE, ifA.PASS, ifA.RsTx}, 4'b0111);

    // Data bit 3 of one frame inverted.
    aPlan[2] = 4;
    runA("bit3", 1, 1'b0);
    aPlan[2] = 0;

    // Random corruption of data/stop bits, plus an ignored START mid-run.
    for (int r = 0; r < 2; r++) begin
      nErr = 0;
      for (int k = 0; k < A_NF; k++) begin
        aPlan[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
        if (aPlan[k] != 0) nErr++;
      end
      runA("rand", nErr, r == 1);
    end
    for (int k = 0; k < A_NF; k++) aPlan[k] = 0;

    // Reset in the data bits of the fifth frame, then restart.
    @(posedge clk); #1;
    ifA.START = 1'b1;
    @(posedge clk); #1;
    ifA.START = 1'b0;
    n = 0;
    while (ifA.FRAME_COUNT != 16'd4 && n < 2000) begin @(posedge clk); #1; n++; end
    repeat (40) @(posedge clk);
    #1;
    check("abort_preBusy", {ifA.BUSY, ifA.FRAME_COUNT}, {1'b1, 16'd4});
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_RsTx", ifA.RsTx, 1);
    check("abort_flags", {ifA.BUSY, ifA.DONE, ifA.PASS}, 0);
    check("abort_counts", {ifA.ERR_COUNT, ifA.FRAME_COUNT}, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("abort_idle", {ifA.RsTx, ifA.BUSY}, 2'b10);
    runA("restart", 0, 1'b0);

    // No echo: four timeouts.
    @(posedge clk); #1;
    ifB.START = 1'b1;
    @(posedge clk); #1;
    ifB.START = 1'b0;
    n = 0;
    while (!ifB.DONE && n < 2000) begin @(posedge clk); #1; n++; end
    check("tmo_done", ifB.DONE, 1);
    check("tmo_latency", (n >= 4*(160+64) && n <= 4*(160+64) + 16) ? 1 : 0, 1);
    check("tmo_errCount", ifB.ERR_COUNT, 4);
    check("tmo_frameCount", ifB.FRAME_COUNT, 4);
    check("tmo_pass", {ifB.PASS, ifB.BUSY}, 0);

    // Odd parity, 7 data bits, 2 stop bits.
    runC("parInv", 1'b1, C_NF);
    runC("parClean", 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_loopback_bist.md
UART_LOOPBACK_BIST -- requirements
Module: uart_loopback_bist

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: CLK cycles per bit, legal range 4..65535.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 SHALL have parameter NUM_FRAMES, default 16: frames per test run, legal range 1..65535.
REQ-006 SHALL have parameter SEED, default 8'hA5: first payload, truncated to DATA_BITS.
REQ-007 SHALL have parameter TIMEOUT_CLKS, default 4*CLKS_PER_BIT: idle cycles allowed for a reply.
REQ-008 CLK  input  1  single clock; all state updates on rising edge.
REQ-009 RESET  input  1  synchronous, active-high reset.
REQ-010 START  input  1  one-cycle request to begin a test run.
REQ-011 RsRx  input  1  serial receive line, asynchronous to CLK.
REQ-012 RsTx  output  1  serial transmit line, idle high.
REQ-013 BUSY  output  1  high while a run is in progress.
REQ-014 DONE  output  1  high from run completion until the next accepted START or RESET.
REQ-015 PASS  output  1  valid while DONE=1; high only if ERR_COUNT=0.
REQ-016 ERR_COUNT  output  16  errored frames in the current or last run; saturates at 16'hFFFF.
REQ-017 FRAME_COUNT  output  16  frames completed (received or timed out) in the current run.

Function
REQ-018 START SHALL be accepted only when BUSY=0; an accepted START clears DONE, PASS, ERR_COUNT and FRAME_COUNT, sets BUSY, and loads the payload register with SEED.
REQ-019 START SHALL be ignored while BUSY=1.
REQ-020 The TX FSM SHALL have states IDLE, START_BIT, DATA, PARITY_BIT, STOP, WAIT_RX; PARITY_BIT is skipped when PARITY=0.
REQ-021 RsTx SHALL drive the start bit (0) starting on the cycle after START is accepted, and every bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-022 Data SHALL be sent LSB first; the parity bit makes the count of 1s in data plus parity even (PARITY=1) or odd (PARITY=2); the stop bits are 1.
REQ-023 After the last stop bit, the TX FSM SHALL enter WAIT_RX with RsTx=1 and SHALL not send the next frame until the current frame is resolved, so only one frame is outstanding at a time.
REQ-024 RsRx SHALL pass through a 2-flop synchroniser; a 1-to-0 transition on the synchronised line while the RX FSM is idle starts reception.
REQ-025 RX SHALL sample the middle of the start bit after CLKS_PER_BIT/2 cycles (integer division); a sample of 1 is a false start, the RX FSM returns to idle, and nothing is counted.
REQ-026 RX SHALL sample each later bit at intervals of CLKS_PER_BIT; the received frame is resolved at the mid-point of the last stop bit.
REQ-027 A received frame SHALL be errored if its data differs from the transmitted payload, the parity check fails, or any stop bit samples 0.
REQ-028 If RX has not started within TIMEOUT_CLKS cycles of entering WAIT_RX, the frame SHALL resolve as a timeout, which counts as an error.
REQ-029 On each resolution, FRAME_COUNT SHALL increment by 1 and ERR_COUNT SHALL increment by 1 if the frame is errored, saturating at 16'hFFFF, both in the same cycle.
REQ-030 The payload SHALL then increment modulo 2^DATA_BITS, wrapping from all-ones to 0.
REQ-031 If FRAME_COUNT reaches NUM_FRAMES, then on the next cycle BUSY=0, DONE=1, and PASS=(ERR_COUNT==0); otherwise the next frame's start bit begins on the next cycle.
REQ-032 A received frame that arrives after a timeout SHALL be discarded without being counted.

Reset
REQ-033 While RESET=1, the block SHALL set RsTx=1, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FRAME_COUNT=0, both FSMs to idle, and the synchroniser flops to 1.
REQ-034 RESET SHALL take priority over a START in the same cycle.
REQ-035 RESET mid-frame SHALL abort the frame, with RsTx=1 from the first clock edge of the reset.

Verification
REQ-036 Defaults, RsRx tied to RsTx, pulse START -> 16 frames with payloads A5..B4, then DONE=1, PASS=1, ERR_COUNT=0, FRAME_COUNT=16, and the first start bit appears one cycle after START.
REQ-037 RsRx held at 1, NUM_FRAMES=4 -> 4 timeouts, ERR_COUNT=4, PASS=0, DONE after 4*(160+64)+small sync overhead cycles.
REQ-038 Loopback with data bit 3 of frame 2 inverted -> ERR_COUNT=1, PASS=0, FRAME_COUNT=16.
REQ-039 PARITY=2, DATA_BITS=7, STOP_BITS=2, with the parity bit inverted on every frame -> ERR_COUNT=NUM_FRAMES; with a clean loopback, PASS=1.
REQ-040 RESET asserted during frame 5 data bits -> RsTx=1, BUSY=0, counts 0; a later START restarts from SEED.
REQ-041 Second START while BUSY, and a 2-cycle low glitch on RsRx while idle -> no effect on counts or the payload sequence.
